// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
//
// Purpose:
//   Multi-cycle unsigned restoring divider. It computes
//     quotient  = dividend / divisor
//     remainder = dividend % divisor
//   and retires one quotient bit per clock. It is used by the arithmetic-encoder
//   datapath for range/probability normalisation. Both the operand side and the
//   result side use a valid/ready handshake, and only one operation is in
//   flight at a time.
//
// Parameters:
//   WIDTH        operand, quotient and remainder width in bits (>= 2)
//
// Ports:
//   clk          in   1      clock; all state changes on the rising edge
//   reset        in   1      asynchronous, active-high reset
//   in_valid     in   1      dividend/divisor valid
//   in_ready     out  1      block can accept an operation (high only in IDLE)
//   dividend     in   WIDTH  unsigned dividend, sampled on accept
//   divisor      in   WIDTH  unsigned divisor, sampled on accept
//   out_valid    out  1      quotient/remainder/div_by_zero valid (DONE state)
//   out_ready    in   1      consumer takes the result
//   quotient     out  WIDTH  unsigned quotient
//   remainder    out  WIDTH  unsigned remainder
//   div_by_zero  out  1      result came from divisor == 0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module seq_restoring_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // Step counter only has to hold WIDTH-1, so clog2(WIDTH) bits are enough.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W    = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Architectural state.
  state_t           state_q,     state_d;
  logic [WIDTH-1:0] r_q,         r_d;       // partial remainder
  logic [WIDTH-1:0] q_q,         q_d;       // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] d_q,         d_d;       // captured divisor
  logic [CNT_W-1:0] cnt_q,       cnt_d;     // remaining restoring steps minus one
  logic             dbz_q,       dbz_d;     // divide-by-zero flag
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;

  // Restoring-step datapath: trial subtraction of the divisor from the
  // partial remainder with the next dividend bit shifted in.
  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH:0]   trial_s;
  logic             trial_neg_s;

  assign rem_shift_s = {r_q, q_q[WIDTH-1]};
  assign trial_s     = rem_shift_s - {1'b0, d_q};
  // Because R < D is maintained, {R, bit} < 2*D, so bit WIDTH of the
  // (WIDTH+1)-bit difference is a reliable sign bit.
  assign trial_neg_s = trial_s[WIDTH];

  // Next-state and datapath update for the IDLE / CALC / DONE controller.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (divisor == ZERO_W) begin
            // Divide by zero is resolved at the accept edge itself.
            r_d     = dividend;
            q_d     = ONES_W;
            d_d     = divisor;
            cnt_d   = CNT_ZERO;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            r_d     = ZERO_W;
            q_d     = dividend;
            d_d     = divisor;
            cnt_d   = CNT_LAST;
            dbz_d   = 1'b0;
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        if (trial_neg_s) begin
          // Restore: keep the shifted remainder, quotient bit 0.
          r_d = rem_shift_s[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end else begin
          r_d = trial_s[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end

        if (cnt_q == CNT_ZERO) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end

      ST_DONE: begin
        // Result held until the consumer takes it.
        if (out_ready) begin
          dbz_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        // Unreachable encoding: recover to IDLE with a clean result.
        r_d     = ZERO_W;
        q_d     = ZERO_W;
        cnt_d   = CNT_ZERO;
        dbz_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are registered and decoded from the next state so they
  // line up exactly with the state register.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_d)
      ST_IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
      ST_CALC: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
      ST_DONE: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
      end
      default: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset to an empty IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      r_q         <= ZERO_W;
      q_q         <= ZERO_W;
      d_q         <= ZERO_W;
      cnt_q       <= CNT_ZERO;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
`timescale 1ns/1ps

module tb_seq_restoring_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_restoring_divider #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Present operands, wait (bounded) for acceptance; returns after edge N + #1.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'hDEAD;
    divisor  = 16'h0003;
  endtask

  // Count edges after edge N until out_valid; bounded.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk(tag, lat, exp_lat);
  endtask

  // Take the result and check the block is back in IDLE right after.
  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ov_after"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_rdy_after"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_dbz_after"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  initial begin
    logic [15:0] a, b;
    logic [31:0] recon;
    int          lat_exp;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 16'd0;
    divisor   = 16'd0;

    // Reset state
    #2;
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quotient",  {16'd0, quotient}, 32'd0);
    chk("rst_remainder", {16'd0, remainder}, 32'd0);
    chk("rst_dbz",       {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: 100 / 7 with out_ready held high
    out_ready = 1'b1;
    start_op(16'd100, 16'd7);
    chk("t1_ov_calc", {31'd0, out_valid}, 32'd0);
    wait_done("t1_latency", 16);
    chk("t1_q",   {16'd0, quotient}, 32'd14);
    chk("t1_r",   {16'd0, remainder}, 32'd2);
    chk("t1_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t1_ov_after",  {31'd0, out_valid}, 32'd0);
    chk("t1_rdy_after", {31'd0, in_ready}, 32'd1);

    // 2: 0xFFFF / 1, then 5 / 9
    start_op(16'hFFFF, 16'd1);
    wait_done("t2a_latency", 16);
    chk("t2a_q", {16'd0, quotient}, 32'h0000FFFF);
    chk("t2a_r", {16'd0, remainder}, 32'd0);
    take_result("t2a");
    start_op(16'd5, 16'd9);
    wait_done("t2b_latency", 16);
    chk("t2b_q", {16'd0, quotient}, 32'd0);
    chk("t2b_r", {16'd0, remainder}, 32'd5);
    take_result("t2b");

    // 3: divide by zero resolves at the accept edge
    start_op(16'h1234, 16'd0);
    wait_done("t3_latency", 0);
    chk("t3_q",   {16'd0, quotient}, 32'h0000FFFF);
    chk("t3_r",   {16'd0, remainder}, 32'h00001234);
    chk("t3_dbz", {31'd0, div_by_zero}, 32'd1);
    take_result("t3");

    // 4: backpressure on 60000 / 255, with ignored in_valid during CALC/DONE
    start_op(16'd60000, 16'd255);
    in_valid = 1'b1;
    dividend = 16'd77;
    divisor  = 16'd0;
    @(posedge clk); #1;
    chk("t4_rdy_calc", {31'd0, in_ready}, 32'd0);
    wait_done("t4_latency", 15);
    for (int k = 0; k < 5; k++) begin
      chk("t4_ov_hold",  {31'd0, out_valid}, 32'd1);
      chk("t4_rdy_hold", {31'd0, in_ready}, 32'd0);
      chk("t4_q_hold",   {16'd0, quotient}, 32'd235);
      chk("t4_r_hold",   {16'd0, remainder}, 32'd75);
      chk("t4_dbz_hold", {31'd0, div_by_zero}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    take_result("t4");

    // 5: reset in the middle of CALC, then 1000 / 33
    start_op(16'd100, 16'd7);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_ov_rst",  {31'd0, out_valid}, 32'd0);
    chk("t5_rdy_rst", {31'd0, in_ready}, 32'd1);
    chk("t5_q_rst",   {16'd0, quotient}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("t5_no_pulse", {31'd0, out_valid}, 32'd0);
    end
    start_op(16'd1000, 16'd33);
    wait_done("t5_latency", 16);
    chk("t5_q", {16'd0, quotient}, 32'd30);
    chk("t5_r", {16'd0, remainder}, 32'd10);
    take_result("t5");

    // 6: random and corner operands against the arithmetic invariants
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom_range(1, 65535));
      if (i % 4 == 1) b = 16'($urandom_range(1, 300));
      if (i % 7 == 0) a = 16'hFFFF;
      if (i % 11 == 0) a = 16'd0;
      if (i % 13 == 0) b = 16'hFFFF;
      if (i % 17 == 0) b = 16'd1;
      if (i % 50 == 3) b = 16'd0;
      lat_exp = (b == 16'd0) ? 0 : 16;
      start_op(a, b);
      wait_done("r_latency", lat_exp);
      if (b == 16'd0) begin
        chk("r_dbz_q",   {16'd0, quotient}, 32'h0000FFFF);
        chk("r_dbz_r",   {16'd0, remainder}, {16'd0, a});
        chk("r_dbz_flag", {31'd0, div_by_zero}, 32'd1);
      end else begin
        recon = ({16'd0, quotient} * {16'd0, b}) + {16'd0, remainder};
        chk("r_invariant", recon, {16'd0, a});
        chk("r_rem_lt_d", {31'd0, (remainder < b)}, 32'd1);
        chk("r_q", {16'd0, quotient}, {16'd0, a / b});
        chk("r_dbz_flag", {31'd0, div_by_zero}, 32'd0);
      end
      take_result("r");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
